// File: rtl/score_collector.sv
// Collects per-lane scoring results into a round-robin ready/valid stream and
// tracks the running maximum {id, score} and result count of the current query.
module score_collector #(
    parameter int unsigned SCORE_WIDTH = 12,
    parameter int unsigned ID_WIDTH    = 48,
    parameter int unsigned MODULES     = 2,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned LANE_WIDTH  = ($clog2(2 * MODULES) > 0) ? $clog2(2 * MODULES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic [CNT_WIDTH-1:0]            expected,
    input  logic [2*MODULES*SCORE_WIDTH-1:0] results,
    input  logic [2*MODULES*ID_WIDTH-1:0]   IDs,
    input  logic [2*MODULES-1:0]            vld,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SCORE_WIDTH-1:0]          out_score,
    output logic [ID_WIDTH-1:0]             out_id,
    output logic [LANE_WIDTH-1:0]           out_lane,
    output logic [ID_WIDTH+SCORE_WIDTH-1:0] max,
    output logic                            max_vld,
    output logic                            overflow
);

    localparam int unsigned LANES   = 2 * MODULES;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W  = PTR_W + 1;
    localparam int unsigned PC_W    = $clog2(LANES + 1);
    localparam int unsigned CNT_EXT = CNT_WIDTH + 1;

    typedef struct packed {
        logic [SCORE_WIDTH-1:0] score;
        logic [ID_WIDTH-1:0]    id;
        logic [LANE_WIDTH-1:0]  lane;
    } entry_t;

    logic [SCORE_WIDTH-1:0] lane_score [LANES];
    logic [ID_WIDTH-1:0]    lane_id    [LANES];
    logic [SCORE_WIDTH-1:0] h_score    [LANES];
    logic [ID_WIDTH-1:0]    h_id       [LANES];
    logic [LANES-1:0]       occ;
    logic [LANES-1:0]       grant_oh;
    logic                   grant_any;
    logic [LANE_WIDTH-1:0]  grant_idx;
    logic [LANE_WIDTH-1:0]  li_a;
    logic [LANE_WIDTH-1:0]  li_m;
    logic [LANE_WIDTH-1:0]  rr_q;
    logic                   pop;
    logic                   can_push;

    entry_t                 mem [FIFO_DEPTH];
    entry_t                 push_data;
    entry_t                 head_q;
    entry_t                 head_n;
    logic [PTR_W-1:0]       wr_q;
    logic [PTR_W-1:0]       rd_q;
    logic [PTR_W-1:0]       rd_n;
    logic [FCNT_W-1:0]      fcnt_q;
    logic [FCNT_W-1:0]      fcnt_n;
    logic [FCNT_W-1:0]      after_pop;

    logic [SCORE_WIDTH-1:0] max_score_q;
    logic [ID_WIDTH-1:0]    max_id_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   found;
    logic [SCORE_WIDTH-1:0] best_s;
    logic [ID_WIDTH-1:0]    best_id;
    logic [PC_W-1:0]        pc;
    logic [SCORE_WIDTH-1:0] max_score_n;
    logic [ID_WIDTH-1:0]    max_id_n;
    logic [CNT_WIDTH-1:0]   base_cnt;
    logic [CNT_EXT-1:0]     cnt_sum;
    logic [CNT_WIDTH-1:0]   count_n;
    logic                   drop_any;

    // One-entry holding register per lane; a grant in the same cycle frees room for a reload.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic                   occ_q;
        logic [SCORE_WIDTH-1:0] score_q;
        logic [ID_WIDTH-1:0]    id_q;

        assign lane_score[g] = results[g*SCORE_WIDTH +: SCORE_WIDTH];
        assign lane_id[g]    = IDs[g*ID_WIDTH +: ID_WIDTH];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                occ_q   <= 1'b0;
                score_q <= '0;
                id_q    <= '0;
            end else if (vld[g] && (!occ_q || grant_oh[g])) begin
                occ_q   <= 1'b1;
                score_q <= lane_score[g];
                id_q    <= lane_id[g];
            end else if (grant_oh[g]) begin
                occ_q   <= 1'b0;
            end
        end

        assign occ[g]     = occ_q;
        assign h_score[g] = score_q;
        assign h_id[g]    = id_q;
    end

    assign drop_any = |(vld & occ & ~grant_oh);

    // Round-robin arbiter: first occupied lane at or after rr_q, only if the FIFO can take it.
    always_comb begin
        pop       = out_valid && out_ready;
        can_push  = (fcnt_q != FCNT_W'(FIFO_DEPTH)) || pop;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        li_a      = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            li_a = LANE_WIDTH'((32'(rr_q) + k) % LANES);
            if (can_push && !grant_any && occ[li_a]) begin
                grant_any      = 1'b1;
                grant_idx      = li_a;
                grant_oh[li_a] = 1'b1;
            end
        end
    end

    // FIFO bookkeeping; the head is re-registered so out_* come straight from flops.
    always_comb begin
        push_data.score = h_score[grant_idx];
        push_data.id    = h_id[grant_idx];
        push_data.lane  = grant_idx;
        case ({grant_any, pop})
            2'b10:   fcnt_n = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_n = fcnt_q - FCNT_W'(1);
            default: fcnt_n = fcnt_q;
        endcase
        after_pop = pop ? fcnt_q - FCNT_W'(1) : fcnt_q;
        rd_n      = pop ? rd_q + PTR_W'(1) : rd_q;
        if (fcnt_n == '0) begin
            head_n = '0;
        end else if (after_pop == '0) begin
            head_n = push_data;
        end else begin
            head_n = mem[rd_n];
        end
    end

    // Best result among this cycle's valid lanes, folded into the query max and count.
    always_comb begin
        found   = 1'b0;
        best_s  = '0;
        best_id = '0;
        pc      = '0;
        li_m    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            li_m = LANE_WIDTH'(i);
            if (vld[li_m]) begin
                pc = pc + PC_W'(1);
                if (!found || (lane_score[li_m] > best_s)) begin
                    found   = 1'b1;
                    best_s  = lane_score[li_m];
                    best_id = lane_id[li_m];
                end
            end
        end
        max_score_n = clear ? '0 : max_score_q;
        max_id_n    = clear ? '0 : max_id_q;
        if (found && (clear || (best_s > max_score_q))) begin
            max_score_n = best_s;
            max_id_n    = best_id;
        end
        base_cnt = clear ? '0 : count_q;
        cnt_sum  = {1'b0, base_cnt} + CNT_EXT'(pc);
        count_n  = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (grant_any) begin
            mem[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q        <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            fcnt_q      <= '0;
            head_q      <= '0;
            out_valid   <= 1'b0;
            max_score_q <= '0;
            max_id_q    <= '0;
            count_q     <= '0;
            max_vld     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (grant_any) begin
                rr_q <= LANE_WIDTH'((32'(grant_idx) + 32'd1) % LANES);
                wr_q <= wr_q + PTR_W'(1);
            end
            rd_q        <= rd_n;
            fcnt_q      <= fcnt_n;
            head_q      <= head_n;
            out_valid   <= (fcnt_n != '0);
            max_score_q <= max_score_n;
            max_id_q    <= max_id_n;
            count_q     <= count_n;
            max_vld     <= (count_n == expected) && (expected != '0);
            overflow    <= (clear ? 1'b0 : overflow) | drop_any;
        end
    end

    assign out_score = head_q.score;
    assign out_id    = head_q.id;
    assign out_lane  = head_q.lane;
    assign max       = {max_id_q, max_score_q};

endmodule

// File: tb/tb_score_collector.sv
// Directed bench for score_collector: scoreboard of expected stream items plus
// direct checks of max/max_vld/overflow around reset, clear and back-pressure.
module tb_score_collector;

    localparam int unsigned SW = 12;
    localparam int unsigned IW = 48;
    localparam int unsigned L  = 4;

    logic            clk;
    logic            rst;
    logic            clear;
    logic [15:0]     expected;
    logic [L*SW-1:0] results;
    logic [L*IW-1:0] ids;
    logic [L-1:0]    vld;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   out_score;
    logic [IW-1:0]   out_id;
    logic [1:0]      out_lane;
    logic [IW+SW-1:0] max;
    logic            max_vld;
    logic            overflow;

    typedef struct {
        logic [SW-1:0] s;
        logic [IW-1:0] id;
        logic [1:0]    lane;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    score_collector dut (
        .clk(clk), .rst(rst), .clear(clear), .expected(expected),
        .results(results), .IDs(ids), .vld(vld),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_score(out_score), .out_id(out_id), .out_lane(out_lane),
        .max(max), .max_vld(max_vld), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [SW-1:0] s, input logic [IW-1:0] id);
        results[i*SW +: SW] = s;
        ids[i*IW +: IW]     = id;
    endtask

    task automatic push_exp(input logic [SW-1:0] s, input logic [IW-1:0] id, input logic [1:0] lane);
        exp_t e;
        e.s = s; e.id = id; e.lane = lane;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 100; c++) begin
            if (sb.size() == 0 && !out_valid) break;
            step();
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every accepted head is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out actual lane=%0d score=%0h required none", out_lane, out_score);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_score", 64'(out_score), 64'(e.s));
                chk("out_id",    64'(out_id),    64'(e.id));
                chk("out_lane",  64'(out_lane),  64'(e.lane));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; clear = 1'b0; expected = '0; results = '0; ids = '0;
        vld = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_max",       64'(max),       64'd0);
        chk("rst_max_vld",   64'(max_vld),   64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        chk("rst_out_score", 64'(out_score), 64'd0);
        rst = 1'b1;
        step();

        // single lane-0 result, two-edge latency
        out_ready = 1'b1;
        set_lane(0, 12'h810, 48'd5);
        vld = 4'b0001;
        push_exp(12'h810, 48'd5, 2'd0);
        step();
        vld = '0;
        chk("t1_lat1_valid", 64'(out_valid), 64'd0);
        step();
        chk("t1_lat2_valid", 64'(out_valid), 64'd1);
        chk("t1_max", 64'(max), 64'({48'd5, 12'h810}));
        wait_drain("t1_drain");

        rst = 1'b0;
        step();
        rst = 1'b1;
        step();

        // four lanes at once, tie on max resolves to lower lane
        expected = 16'd4;
        set_lane(0, 12'h805, 48'd200);
        set_lane(1, 12'h820, 48'd201);
        set_lane(2, 12'h820, 48'd202);
        set_lane(3, 12'h801, 48'd203);
        push_exp(12'h805, 48'd200, 2'd0);
        push_exp(12'h820, 48'd201, 2'd1);
        push_exp(12'h820, 48'd202, 2'd2);
        push_exp(12'h801, 48'd203, 2'd3);
        vld = 4'b1111;
        chk("t2_max_vld_before", 64'(max_vld), 64'd0);
        step();
        vld = '0;
        chk("t2_max_vld", 64'(max_vld), 64'd1);
        chk("t2_max", 64'(max), 64'({48'd201, 12'h820}));
        chk("t2_overflow", 64'(overflow), 64'd0);
        wait_drain("t2_drain");

        // fill FIFO, hold four more, then drop a wave
        out_ready = 1'b0;
        clear = 1'b1;
        expected = 16'd24;
        step();
        clear = 1'b0;
        for (int w = 0; w < 5; w++) begin
            for (int l = 0; l < 4; l++) begin
                set_lane(l, 12'(12'h100 + w * 16 + l), 48'(1000 + w * 10 + l));
                push_exp(12'(12'h100 + w * 16 + l), 48'(1000 + w * 10 + l), 2'(l));
            end
            vld = 4'b1111;
            step();
            vld = '0;
            repeat (5) step();
        end
        chk("t3_full_valid", 64'(out_valid), 64'd1);
        chk("t3_no_ovf_yet", 64'(overflow), 64'd0);
        chk("t3_max_vld_20", 64'(max_vld), 64'd0);
        for (int l = 0; l < 4; l++) set_lane(l, 12'(12'h150 + l), 48'(2000 + l));
        set_lane(2, 12'hff0, 48'd2002);
        vld = 4'b1111;
        step();
        vld = '0;
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_max_vld_24", 64'(max_vld), 64'd1);
        chk("t3_max_dropped", 64'(max), 64'({48'd2002, 12'hff0}));
        out_ready = 1'b1;
        wait_drain("t3_drain");

        // clear with a same-cycle result
        clear = 1'b1;
        expected = 16'd1;
        set_lane(2, 12'h900, 48'd77);
        vld = 4'b0100;
        push_exp(12'h900, 48'd77, 2'd2);
        step();
        clear = 1'b0;
        vld = '0;
        chk("t4_overflow", 64'(overflow), 64'd0);
        chk("t4_max_vld", 64'(max_vld), 64'd1);
        chk("t4_max", 64'(max), 64'({48'd77, 12'h900}));
        wait_drain("t4_drain");

        // async reset with items in flight
        out_ready = 1'b0;
        clear = 1'b1;
        expected = 16'd3;
        for (int l = 0; l < 3; l++) set_lane(l, 12'(12'h300 + l), 48'(300 + l));
        vld = 4'b0111;
        step();
        clear = 1'b0;
        vld = '0;
        repeat (4) step();
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        chk("t5_pre_max_vld", 64'(max_vld), 64'd1);
        chk("t5_pre_max", 64'(max), 64'({48'd302, 12'h302}));
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_valid", 64'(out_valid), 64'd0);
        chk("t5_async_max", 64'(max), 64'd0);
        chk("t5_async_max_vld", 64'(max_vld), 64'd0);
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (5) step();
        chk("t5_no_replay", 64'(out_valid), 64'd0);

        // lanes 0 and 3 always busy: grants alternate
        expected = '0;
        set_lane(0, 12'h200, 48'd10);
        set_lane(3, 12'h300, 48'd13);
        for (int n = 0; n < 5; n++) begin
            push_exp(12'h200, 48'd10, 2'd0);
            push_exp(12'h300, 48'd13, 2'd3);
        end
        vld = 4'b1001;
        repeat (9) step();
        vld = '0;
        wait_drain("t6_drain");
        chk("t6_overflow", 64'(overflow), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
